// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM states and flag bit positions shared by the alu_seq block.
package alu_pkg;
   localparam int OP_BITS = 3;
   localparam logic [OP_BITS-1:0] OP_ADD = 3'b000;
   localparam logic [OP_BITS-1:0] OP_SUB = 3'b001;
   localparam logic [OP_BITS-1:0] OP_AND = 3'b010;
   localparam logic [OP_BITS-1:0] OP_OR  = 3'b011;
   localparam logic [OP_BITS-1:0] OP_XOR = 3'b100;
   localparam logic [OP_BITS-1:0] OP_SLL = 3'b101;
   localparam logic [OP_BITS-1:0] OP_SRL = 3'b110;
   localparam logic [OP_BITS-1:0] OP_MUL = 3'b111;
   typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;
   localparam int FLG_Z = 3;
   localparam int FLG_N = 2;
   localparam int FLG_C = 1;
   localparam int FLG_V = 0;
endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: shift-add unsigned multiplier, one multiplier bit per clock.
module alu_mul_seq #(
   parameter int E_BITS = 16
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_start,
   input  logic [E_BITS-1:0]     i_a,
   input  logic [E_BITS-1:0]     i_b,
   output logic                  o_busy,
   output logic                  o_last,
   output logic [2*E_BITS-1:0]   o_product
);
   localparam int CW = $clog2(E_BITS);
   logic [2*E_BITS-1:0] mcand_q, prod_q, a_ext;
   logic [E_BITS-1:0]   mplr_q;
   logic [CW-1:0]       cnt_q;
   logic                busy_q;
   assign a_ext     = {{E_BITS{1'b0}}, i_a};
   // o_product is the product including this cycle's step, valid for capture when o_last
   assign o_product = prod_q + (mplr_q[0] ? mcand_q : '0);
   assign o_busy    = busy_q;
   assign o_last    = busy_q && cnt_q == CW'(1);
   // The start edge already folds in bit 0, so E_BITS-1 busy edges remain
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         busy_q  <= 1'b0;
         cnt_q   <= '0;
         mcand_q <= '0;
         mplr_q  <= '0;
         prod_q  <= '0;
      end else if (i_start) begin
         busy_q  <= 1'b1;
         cnt_q   <= CW'(E_BITS - 1);
         mcand_q <= a_ext << 1;
         mplr_q  <= i_b >> 1;
         prod_q  <= i_b[0] ? a_ext : '0;
      end else if (busy_q) begin
         busy_q  <= cnt_q != CW'(1);
         cnt_q   <= cnt_q - CW'(1);
         mcand_q <= mcand_q << 1;
         mplr_q  <= mplr_q >> 1;
         prod_q  <= o_product;
      end
   end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered 8-op ALU with Z/N/C/V flags and valid/ready/done handshake.
module alu_seq
   import alu_pkg::*;
#(
   parameter int E_BITS = 16
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_valid,
   input  logic [OP_BITS-1:0] i_op,
   input  logic [E_BITS-1:0]  op_1,
   input  logic [E_BITS-1:0]  op_2,
   output logic               o_ready,
   output logic               o_done,
   output logic [E_BITS-1:0]  o_res,
   output logic [3:0]         o_flags
);
   localparam int SH = $clog2(E_BITS);
   localparam int M  = E_BITS - 1;
   state_t              state_q, state_d;
   logic [E_BITS-1:0]   res_q, res_d, alu_res;
   logic [3:0]          flags_q, flags_d;
   logic                done_q, done_d, alu_c, alu_v, accept;
   logic [E_BITS:0]     sum, diff, sll_x, srl_x;
   logic [SH-1:0]       amt;
   logic                mul_start, mul_busy, mul_last;
   logic [2*E_BITS-1:0] mul_prod;
   assign o_ready   = state_q == ST_IDLE && !mul_busy;
   assign o_done    = done_q;
   assign o_res     = res_q;
   assign o_flags   = flags_q;
   assign accept    = i_valid && o_ready;
   assign mul_start = accept && i_op == OP_MUL;
   assign amt       = op_2[SH-1:0];
   assign sum       = {1'b0, op_1} + {1'b0, op_2};
   assign diff      = {1'b0, op_1} - {1'b0, op_2};
   // One extra bit on each shift catches the last bit shifted out
   assign sll_x     = {1'b0, op_1} << amt;
   assign srl_x     = {op_1, 1'b0} >> amt;
   alu_mul_seq #(.E_BITS(E_BITS)) u_mul (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_start  (mul_start),
      .i_a      (op_1),
      .i_b      (op_2),
      .o_busy   (mul_busy),
      .o_last   (mul_last),
      .o_product(mul_prod)
   );
   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (i_op)
         OP_ADD: begin
            alu_res = sum[M:0];
            alu_c   = sum[E_BITS];
            alu_v   = (op_1[M] == op_2[M]) && (sum[M] != op_1[M]);
         end
         OP_SUB: begin
            alu_res = diff[M:0];
            alu_c   = diff[E_BITS];
            alu_v   = (op_1[M] != op_2[M]) && (diff[M] != op_1[M]);
         end
         OP_AND: alu_res = op_1 & op_2;
         OP_OR:  alu_res = op_1 | op_2;
         OP_XOR: alu_res = op_1 ^ op_2;
         OP_SLL: begin
            alu_res = sll_x[M:0];
            alu_c   = sll_x[E_BITS];
         end
         OP_SRL: begin
            alu_res = srl_x[E_BITS:1];
            alu_c   = srl_x[0];
         end
         default: alu_res = '0;
      endcase
   end
   always_comb begin
      state_d = state_q;
      res_d   = res_q;
      flags_d = flags_q;
      done_d  = 1'b0;
      if (accept && i_op != OP_MUL) begin
         res_d          = alu_res;
         flags_d[FLG_Z] = alu_res == '0;
         flags_d[FLG_N] = alu_res[M];
         flags_d[FLG_C] = alu_c;
         flags_d[FLG_V] = alu_v;
         done_d         = 1'b1;
      end else if (mul_start) begin
         state_d = ST_BUSY;
      end else if (state_q == ST_BUSY && mul_last) begin
         res_d          = mul_prod[M:0];
         flags_d[FLG_Z] = mul_prod[M:0] == '0;
         flags_d[FLG_N] = mul_prod[M];
         flags_d[FLG_C] = |mul_prod[2*E_BITS-1:E_BITS];
         flags_d[FLG_V] = 1'b0;
         done_d         = 1'b1;
         state_d        = ST_IDLE;
      end
   end
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= ST_IDLE;
         res_q   <= '0;
         flags_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         res_q   <= res_d;
         flags_q <= flags_d;
         done_q  <= done_d;
      end
   end
endmodule
